// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: data widths,
// funct3 access encodings, LSU state encoding and access-legality helpers.
package mem_stage_lsu_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int RS_WIDTH       = 5;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size field (funct3[1:0])
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [0:0] {
    LSU_IDLE     = 1'b0,
    LSU_WAIT_RSP = 1'b1
  } lsu_state_e;

  // True when funct3 names a supported access of the given direction.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_load) begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // True when the byte offset is not naturally aligned for the access size.
  function automatic logic f3_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_HALF: mis = off[0];
      SIZE_WORD: mis = |off;
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for the LSU: store byte enables / replicated write
// data, and load byte/half extraction with sign or zero extension.
// Purely combinational.
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [1:0]                st_size_i_unused_guard_n,
  input  logic [1:0]                i_st_size,
  input  logic [1:0]                i_st_off,
  input  logic [REG_DATA_WIDTH-1:0] i_st_data,
  output logic [3:0]                o_st_be,
  output logic [REG_DATA_WIDTH-1:0] o_st_wdata,
  input  logic [2:0]                i_ld_funct3,
  input  logic [1:0]                i_ld_off,
  input  logic [REG_DATA_WIDTH-1:0] i_ld_rdata,
  output logic [REG_DATA_WIDTH-1:0] o_ld_data
);

  logic [4:0]  w_byte_lsb;
  logic [4:0]  w_half_lsb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_guard;

  assign w_guard    = ^st_size_i_unused_guard_n;
  assign w_byte_lsb = {i_ld_off, 3'b000};
  assign w_half_lsb = {i_ld_off[1], 4'b0000};
  assign w_byte     = i_ld_rdata[w_byte_lsb +: 8];
  assign w_half     = i_ld_rdata[w_half_lsb +: 16];

  // Store lane steering: shift enables to the addressed lane, replicate data.
  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_data;
    case (i_st_size)
      SIZE_BYTE: begin
        o_st_be    = 4'b0001 << i_st_off;
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      SIZE_HALF: begin
        o_st_be    = 4'b0011 << i_st_off;
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        o_st_be    = 4'b1111;
        o_st_wdata = (w_guard & 1'b0) ? {REG_DATA_WIDTH{1'b0}} : i_st_data;
      end
    endcase
  end

  // Load extraction: select the addressed lane and extend per funct3.
  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_funct3)
      F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_ld_data = {24'h000000, w_byte};
      F3_LHU:  o_ld_data = {16'h0000, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Issues data-memory requests from the EX/MEM
// controls, stalls the pipeline while the handshake is outstanding, extends
// load data for MEM/WB and guards the read response with a watchdog.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr_mem,
  input  logic [XLEN-1:0] store_data_mem,
  input  logic            memread_mem,
  input  logic            memwrite_mem,
  input  logic [2:0]      funct3_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] data_i_mem,
  output logic            mem_stall,
  output logic            access_exc,
  output logic            bus_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e      r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [XLEN-1:0] r_hold;

  logic            w_access;
  logic            w_exc_raw;
  logic            w_is_wait;
  logic            w_req_idle;
  logic            w_rsp;
  logic            w_expire;
  logic [3:0]      w_st_be;
  logic [XLEN-1:0] w_st_wdata;
  logic [XLEN-1:0] w_ld_data;

  assign w_access   = memread_mem ^ memwrite_mem;
  assign w_exc_raw  = (memread_mem & memwrite_mem) |
                      (w_access & (~f3_legal(memread_mem, funct3_mem) |
                                   f3_misaligned(funct3_mem[1:0], addr_mem[1:0])));
  assign w_is_wait  = (r_state == LSU_WAIT_RSP);
  assign w_req_idle = ~w_is_wait & w_access & ~w_exc_raw;
  assign w_rsp      = w_is_wait & dmem_rvalid;
  // A response arriving on the last watchdog cycle wins over the timeout.
  assign w_expire   = w_is_wait & ~dmem_rvalid & (r_cnt == CNT_MAX);

  mem_stage_lsu_align u_align (
    .st_size_i_unused_guard_n (2'b00),
    .i_st_size                (funct3_mem[1:0]),
    .i_st_off                 (addr_mem[1:0]),
    .i_st_data                (store_data_mem),
    .o_st_be                  (w_st_be),
    .o_st_wdata               (w_st_wdata),
    .i_ld_funct3              (r_funct3),
    .i_ld_off                 (r_off),
    .i_ld_rdata               (dmem_rdata),
    .o_ld_data                (w_ld_data)
  );

  // Output drive: request/stall decode and load data forwarding, all forced low in reset.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = {XLEN{1'b0}};
    dmem_be    = 4'b0000;
    dmem_wdata = {XLEN{1'b0}};
    data_i_mem = {XLEN{1'b0}};
    mem_stall  = 1'b0;
    access_exc = 1'b0;
    bus_err    = 1'b0;
    if (!rst) begin
      dmem_req   = w_req_idle;
      dmem_we    = w_req_idle & memwrite_mem;
      dmem_addr  = {addr_mem[XLEN-1:2], 2'b00};
      dmem_be    = memwrite_mem ? w_st_be : 4'b1111;
      dmem_wdata = w_st_wdata;
      access_exc = w_exc_raw;
      bus_err    = w_expire;
      if (w_rsp) begin
        data_i_mem = w_ld_data;
      end else if (w_expire) begin
        data_i_mem = {XLEN{1'b0}};
      end else begin
        data_i_mem = r_hold;
      end
      if (w_is_wait) begin
        mem_stall = ~(w_rsp | w_expire);
      end else begin
        // Loads always stall through the grant cycle; stores only until granted.
        mem_stall = w_req_idle & (memread_mem | ~dmem_gnt);
      end
    end else begin
      dmem_req   = 1'b0;
      data_i_mem = {XLEN{1'b0}};
    end
  end

  // LSU state machine: load capture on grant, watchdog, and load-data hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= LSU_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      r_hold   <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        LSU_IDLE: begin
          r_cnt <= {CW{1'b0}};
          if (w_req_idle & memread_mem & dmem_gnt) begin
            r_state  <= LSU_WAIT_RSP;
            r_funct3 <= funct3_mem;
            r_off    <= addr_mem[1:0];
          end
        end
        LSU_WAIT_RSP: begin
          if (w_rsp) begin
            r_hold  <= w_ld_data;
            r_cnt   <= {CW{1'b0}};
            r_state <= LSU_IDLE;
          end else if (w_expire) begin
            r_hold  <= {XLEN{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_state <= LSU_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= LSU_IDLE;
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios followed by
// randomized loads/stores/illegal accesses against a behavioural model.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic [31:0] addr_mem;
  logic [31:0] store_data_mem;
  logic        memread_mem;
  logic        memwrite_mem;
  logic [2:0]  funct3_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] data_i_mem;
  logic        mem_stall;
  logic        access_exc;
  logic        bus_err;

  int vectors;
  int miscompares;
  logic [31:0] m_hold;   // model of the value MEM/WB should see between loads

  mem_stage_lsu #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .addr_mem(addr_mem), .store_data_mem(store_data_mem),
    .memread_mem(memread_mem), .memwrite_mem(memwrite_mem), .funct3_mem(funct3_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .data_i_mem(data_i_mem), .mem_stall(mem_stall),
    .access_exc(access_exc), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int unsigned m_nbytes(input logic [2:0] f3);
    int unsigned s;
    s = f3 % 4;
    return 1 << s;
  endfunction

  function automatic logic m_exc(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    logic legal;
    if (rd && wr) return 1'b1;
    if (!rd && !wr) return 1'b0;
    if (rd) legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal) return 1'b1;
    return (a % m_nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    int unsigned v;
    n = m_nbytes(f3);
    if (n == 4) v = 15;
    else        v = ((1 << n) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int unsigned n;
    n = m_nbytes(f3);
    if (n == 1) return (d & 32'hFF) * 32'h01010101;
    if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned off;
    int unsigned v;
    off = a % 4;
    case (f3)
      3'd0: begin v = (rd >> (8 * off)) & 255;   if (v >= 128)   v = v + 32'hFFFFFF00; end
      3'd1: begin v = (rd >> (8 * off)) & 65535; if (v >= 32768) v = v + 32'hFFFF0000; end
      3'd4: v = (rd >> (8 * off)) & 255;
      3'd5: v = (rd >> (8 * off)) & 65535;
      default: v = rd;
    endcase
    return v;
  endfunction

  // ---------------- directed transaction helpers ----------------
  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input int gdel);
    memread_mem = 1'b0; memwrite_mem = 1'b1; funct3_mem = f3; addr_mem = a; store_data_mem = d;
    for (int i = 0; i < gdel; i++) begin
      dmem_gnt = 1'b0; #1;
      chk1("st_req_ungnt", dmem_req, 1'b1);
      chk1("st_stall_ungnt", mem_stall, 1'b1);
      chk4("st_be_ungnt", dmem_be, m_be(f3, a));
      tick();
    end
    dmem_gnt = 1'b1; #1;
    chk1("st_req", dmem_req, 1'b1);
    chk1("st_we", dmem_we, 1'b1);
    chk1("st_stall_gnt", mem_stall, 1'b0);
    chk32("st_addr", dmem_addr, a - (a % 4));
    chk4("st_be", dmem_be, m_be(f3, a));
    chk32("st_wdata", dmem_wdata, m_wdata(f3, d));
    chk32("st_data_hold", data_i_mem, m_hold);
    tick();
    dmem_gnt = 1'b0; memwrite_mem = 1'b0; #1;
    chk1("st_after_stall", mem_stall, 1'b0);
    chk32("st_after_hold", data_i_mem, m_hold);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                         input int gdel, input int rdel);
    logic [31:0] exp;
    exp = m_load(f3, a, rd);
    memread_mem = 1'b1; memwrite_mem = 1'b0; funct3_mem = f3; addr_mem = a;
    store_data_mem = $urandom;
    for (int i = 0; i < gdel; i++) begin
      dmem_gnt = 1'b0; #1;
      chk1("ld_req_ungnt", dmem_req, 1'b1);
      chk1("ld_stall_ungnt", mem_stall, 1'b1);
      tick();
    end
    dmem_gnt = 1'b1; #1;
    chk1("ld_req", dmem_req, 1'b1);
    chk1("ld_we", dmem_we, 1'b0);
    chk4("ld_be", dmem_be, 4'b1111);
    chk32("ld_addr", dmem_addr, a - (a % 4));
    chk1("ld_stall_gnt", mem_stall, 1'b1);
    tick();
    dmem_gnt = 1'b0;
    for (int i = 0; i < rdel; i++) begin
      dmem_rvalid = 1'b0; dmem_rdata = $urandom; #1;
      chk1("ld_wait_req", dmem_req, 1'b0);
      chk1("ld_wait_stall", mem_stall, 1'b1);
      chk1("ld_wait_berr", bus_err, 1'b0);
      chk32("ld_wait_hold", data_i_mem, m_hold);
      tick();
    end
    dmem_rvalid = 1'b1; dmem_rdata = rd; #1;
    chk32("ld_data", data_i_mem, exp);
    chk1("ld_rsp_stall", mem_stall, 1'b0);
    chk1("ld_rsp_berr", bus_err, 1'b0);
    tick();
    m_hold = exp;
    memread_mem = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom; #1;
    chk32("ld_hold", data_i_mem, m_hold);
    chk1("ld_idle_stall", mem_stall, 1'b0);
  endtask

  task automatic do_exc(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a);
    memread_mem = rd; memwrite_mem = wr; funct3_mem = f3; addr_mem = a;
    store_data_mem = $urandom; dmem_gnt = 1'($urandom_range(0, 1)); #1;
    chk1("exc_flag", access_exc, 1'b1);
    chk1("exc_req", dmem_req, 1'b0);
    chk1("exc_stall", mem_stall, 1'b0);
    chk32("exc_hold", data_i_mem, m_hold);
    tick();
    memread_mem = 1'b0; memwrite_mem = 1'b0; dmem_gnt = 1'b0; #1;
    chk1("exc_after_flag", access_exc, 1'b0);
    chk1("exc_after_stall", mem_stall, 1'b0);
    chk32("exc_after_hold", data_i_mem, m_hold);
  endtask

  initial begin
    logic        r_rd, r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    int          op;

    vectors = 0; miscompares = 0; m_hold = 32'h0;
    rst = 1'b1; addr_mem = 32'h100; store_data_mem = 32'h0; memread_mem = 1'b1;
    memwrite_mem = 1'b1; funct3_mem = 3'b010; dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    tick(); tick();
    // Reset forces every output low regardless of inputs.
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_we", dmem_we, 1'b0);
    chk32("rst_addr", dmem_addr, 32'h0);
    chk4("rst_be", dmem_be, 4'b0000);
    chk1("rst_stall", mem_stall, 1'b0);
    chk1("rst_exc", access_exc, 1'b0);
    chk1("rst_berr", bus_err, 1'b0);
    chk32("rst_data", data_i_mem, 32'h0);
    memread_mem = 1'b0; memwrite_mem = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    rst = 1'b0;
    tick();

    // Directed scenarios
    do_store(3'b010, 32'h100, 32'hDEADBEEF, 0);
    do_store(3'b000, 32'h103, 32'h000000A5, 2);
    do_load(3'b000, 32'h102, 32'h12803456, 0, 2);
    do_load(3'b100, 32'h102, 32'h12803456, 1, 2);
    do_load(3'b101, 32'h102, 32'h80013456, 0, 0);
    do_load(3'b001, 32'h102, 32'h80013456, 0, 3);
    do_exc(1'b1, 1'b0, 3'b010, 32'h102);
    do_exc(1'b1, 1'b0, 3'b001, 32'h101);
    do_exc(1'b1, 1'b1, 3'b010, 32'h100);
    do_exc(1'b0, 1'b1, 3'b100, 32'h100);

    // Watchdog: load granted, response never arrives.
    memread_mem = 1'b1; memwrite_mem = 1'b0; funct3_mem = 3'b010; addr_mem = 32'h200;
    dmem_gnt = 1'b1; #1;
    chk1("to_req", dmem_req, 1'b1);
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("to_wait_berr", bus_err, 1'b0);
      chk1("to_wait_stall", mem_stall, 1'b1);
      tick();
    end
    #1;
    chk1("to_berr", bus_err, 1'b1);
    chk32("to_data", data_i_mem, 32'h0);
    chk1("to_stall", mem_stall, 1'b0);
    tick();
    m_hold = 32'h0;
    memread_mem = 1'b0; #1;
    chk1("to_berr_pulse", bus_err, 1'b0);
    chk32("to_hold", data_i_mem, 32'h0);
    do_store(3'b010, 32'h204, 32'hCAFEF00D, 0);

    // Randomized mix of loads, stores and illegal accesses.
    for (int n = 0; n < 40; n++) begin
      op   = $urandom_range(0, 4);
      r_rd = (op != 1) && (op != 2);
      r_wr = (op == 1) || (op == 2) || (op == 4);
      r_f3 = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      if ($urandom_range(0, 2) != 0) r_a = r_a & 32'hFFFFFFFC;
      if (m_exc(r_rd, r_wr, r_f3, r_a))
        do_exc(r_rd, r_wr, r_f3, r_a);
      else if (r_rd)
        do_load(r_f3, r_a, $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
      else
        do_store(r_f3, r_a, $urandom, $urandom_range(0, 2));
    end

    // Reset while waiting for a response; the late response must be ignored.
    do_load(3'b010, 32'h300, 32'h89ABCDEF, 0, 0);
    memread_mem = 1'b1; funct3_mem = 3'b010; addr_mem = 32'h304; dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    tick();
    rst = 1'b1; #1;
    chk1("wrst_req", dmem_req, 1'b0);
    chk1("wrst_stall", mem_stall, 1'b0);
    chk32("wrst_data", data_i_mem, 32'h0);
    chk32("wrst_addr", dmem_addr, 32'h0);
    tick();
    rst = 1'b0; memread_mem = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555; #1;
    m_hold = 32'h0;
    chk32("wrst_stray", data_i_mem, 32'h0);
    chk1("wrst_stray_stall", mem_stall, 1'b0);
    chk1("wrst_stray_berr", bus_err, 1'b0);
    tick();
    dmem_rvalid = 1'b0; #1;
    chk32("wrst_hold", data_i_mem, m_hold);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage; sits between the EX/MEM register and the MEM/WB register.
- Turns EX/MEM load/store controls into a data-memory request and handles byte-lane alignment.
- Sign- or zero-extends load data into data_i_mem, which MEM/WB samples.
- Stalls the pipeline while the data-memory handshake is outstanding.

Parameters:
- XLEN, 32, data and address width (equals REG_DATA_WIDTH).
- TIMEOUT_CYCLES, 255, cycles in WAIT_RSP before the response watchdog fires; must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- addr_mem  in  XLEN  effective address (ALU result)
- store_data_mem  in  XLEN  rs2 value for stores
- memread_mem  in  1  load in MEM
- memwrite_mem  in  1  store in MEM
- funct3_mem  in  3  access size and signedness
- dmem_req  out  1  request valid
- dmem_we  out  1  write enable
- dmem_addr  out  XLEN  word-aligned address, addr_mem with bits [1:0] forced to 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read response valid
- dmem_rdata  in  XLEN  read response data
- data_i_mem  out  XLEN  extended load data, to MEM/WB
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; bubbles MEM/WB
- access_exc  out  1  misaligned or illegal access (combinational)
- bus_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. While rst is high:
  - state is IDLE, the watchdog counter is 0, captured regs are 0, data_i_mem is 0.
  - all outputs are 0.
  - Reset in WAIT_RSP abandons the access.
- Access definition: access = memread_mem XOR memwrite_mem.
- access_exc is set when any of the following holds:
  - memread_mem and memwrite_mem are both 1;
  - funct3 is not one of LB 000, LH 001, LW 010, LBU 100, LHU 101 for loads, or SB 000, SH 001, SW 010 for stores;
  - a halfword access has addr[0]=1;
  - a word access has addr[1:0]!=0.
- On access_exc: no request is issued, mem_stall=0, data_i_mem holds its value.
- States: IDLE and WAIT_RSP.
- IDLE:
  - dmem_req = access & !access_exc (combinational; inputs stay stable because of the stall).
  - Store: completes on the dmem_gnt cycle; mem_stall = !dmem_gnt; state stays IDLE.
  - Load: on dmem_gnt, capture funct3 and addr[1:0], go to WAIT_RSP. mem_stall=1 in the grant cycle and while ungranted.
  - dmem_rvalid in IDLE is ignored (stray or post-reset response).
- WAIT_RSP:
  - dmem_req=0, mem_stall=1, counter increments each cycle.
  - On dmem_rvalid: data_i_mem = extended data, combinationally in that cycle and registered for hold afterwards. mem_stall=0, counter cleared, next state IDLE.
  - If counter reaches TIMEOUT_CYCLES-1 without rvalid: bus_err=1 for one cycle, data_i_mem=0, mem_stall=0, next state IDLE.
  - rvalid on the expiry cycle takes priority over the timeout.
- Minimum load latency: 2 cycles (grant, then rvalid). A store granted immediately costs no stall.
- Store lanes, with off = addr[1:0]:
  - SB: be = 4'b0001 << off; wdata = byte replicated ×4.
  - SH: be = 4'b0011 << off; wdata = half replicated ×2.
  - SW: be = 4'b1111; wdata unchanged.
  - Loads drive be = 1111 and dmem_we = 0.
- Load extraction:
  - Byte = rdata[8*off +: 8]; half = rdata[16*off[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- data_i_mem: holds the last completed load value between loads; it is never updated by stores or exceptions.

Decomposition:
- Shared definitions in riscv_def.v: funct3 load/store encodings (LB..SW) and LSU state encodings, defined alongside REG_DATA_WIDTH and RS_WIDTH.
- One natural sub-module, lsu_align: purely combinational. It generates store be/wdata and performs load extraction and extension. The FSM, watchdog and hold register stay in mem_stage_lsu.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt in the same cycle -> req=1, we=1, be=1111, wdata=0xDEADBEEF, mem_stall=0 for the whole access.
- SB addr 0x103, data 0x000000A5, gnt delayed 2 cycles -> be=1000, wdata=0xA5A5A5A5, mem_stall=1 for 2 cycles, then 0 on the gnt cycle.
- LB addr 0x102; rdata 0x12803456 arrives 3 cycles after gnt -> data_i_mem=0xFFFFFF80 on the rvalid cycle; LBU of the same -> 0x00000080; LHU addr 0x102 with rdata 0x80013456 -> 0x00008001. The value is held after the rvalid cycle.
- LW addr 0x102 -> access_exc=1, dmem_req=0, mem_stall=0. LH addr 0x101 -> same response. memread and memwrite both 1 -> access_exc=1.
- LW granted with rvalid never asserted, TIMEOUT_CYCLES=4 -> bus_err pulses on the 4th WAIT_RSP cycle, data_i_mem=0, state IDLE, a following SW issues normally.
- rst asserted in WAIT_RSP, then a late rvalid with 0x55555555 -> next cycle all outputs 0, the stray rvalid is ignored, data_i_mem stays 0.
